// File: rtl/prog_load_ctrl.sv
// Boot-time program loader: assembles a little-endian byte stream into words,
// parses the N_I/N_D header, then writes 128-bit imem lines and 32-bit dmem words.
module prog_load_ctrl #(
    parameter int          ADDR_LEN   = 32,
    parameter int          IMEM_LINES = 512,
    parameter logic [31:0] DMEM_BASE  = 32'h0
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic [ADDR_LEN-1:0] load_addr,
    output logic [127:0]        load_data,
    output logic                imem_we,
    output logic                dmem_we,
    output logic                prog_loading,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_HDR_I,
        ST_HDR_D,
        ST_IMEM,
        ST_DMEM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]          byte_cnt_reg;
    logic [23:0]         partial_reg;
    logic [1:0]          line_word_reg;
    logic [9:0]          line_idx_reg;
    logic [31:0]         word_idx_reg;
    logic [31:0]         n_i_reg;
    logic [31:0]         n_d_reg;
    logic [127:0]        load_data_reg;
    logic [ADDR_LEN-1:0] load_addr_reg;
    logic                imem_we_reg;
    logic                dmem_we_reg;
    logic                rx_ready_reg;
    logic                prog_loading_reg;
    logic                done_reg;
    logic                err_reg;

    logic        accept;
    logic        word_done;
    logic [31:0] word;
    logic [2:0]  lane_we;
    logic        last_line;
    logic        last_word;

    assign accept    = rx_valid && rx_ready_reg;
    assign word_done = accept && (byte_cnt_reg == 2'd3);
    assign word      = {rx_data, partial_reg};
    assign last_line = ({22'd0, line_idx_reg} == (n_i_reg - 32'd1));
    assign last_word = (word_idx_reg == (n_d_reg - 32'd1));

    // Lower three byte lanes are captured as they arrive; the fourth byte
    // completes the word directly from rx_data.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_we[gi] = accept && (byte_cnt_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_reg <= ST_HDR_I;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_HDR_I: begin
                if (word_done) begin
                    state_next = ST_HDR_D;
                end
            end
            ST_HDR_D: begin
                if (word_done) begin
                    if (n_i_reg > 32'(IMEM_LINES)) begin
                        state_next = ST_ERR;
                    end else if (n_i_reg != 32'd0) begin
                        state_next = ST_IMEM;
                    end else if (word != 32'd0) begin
                        state_next = ST_DMEM;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_IMEM: begin
                // Leave only after the last line's strobe has been issued.
                if (imem_we_reg && last_line) begin
                    state_next = (n_d_reg != 32'd0) ? ST_DMEM : ST_DONE;
                end
            end
            ST_DMEM: begin
                if (dmem_we_reg && last_word) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_DONE;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_HDR_I;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            byte_cnt_reg  <= 2'd0;
            partial_reg   <= 24'd0;
            line_word_reg <= 2'd0;
            line_idx_reg  <= 10'd0;
            word_idx_reg  <= 32'd0;
            n_i_reg       <= 32'd0;
            n_d_reg       <= 32'd0;
            load_data_reg <= 128'd0;
            load_addr_reg <= '0;
            imem_we_reg   <= 1'b0;
            dmem_we_reg   <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (lane_we[i]) begin
                    partial_reg[i*8 +: 8] <= rx_data;
                end
            end

            if (word_done) begin
                load_data_reg <= {word, load_data_reg[127:32]};
            end
            if (word_done && (state_reg == ST_HDR_I)) begin
                n_i_reg <= word;
            end
            if (word_done && (state_reg == ST_HDR_D)) begin
                n_d_reg <= word;
            end

            imem_we_reg <= word_done && (state_reg == ST_IMEM) && (line_word_reg == 2'd3);
            dmem_we_reg <= word_done && (state_reg == ST_DMEM);

            if (word_done && (state_reg == ST_IMEM)) begin
                line_word_reg <= line_word_reg + 2'd1;
                if (line_word_reg == 2'd3) begin
                    load_addr_reg <= ADDR_LEN'({line_idx_reg, 4'b0000});
                end
            end
            if (word_done && (state_reg == ST_DMEM)) begin
                load_addr_reg <= ADDR_LEN'(DMEM_BASE + {word_idx_reg[29:0], 2'b00});
            end

            if (imem_we_reg) begin
                line_idx_reg <= line_idx_reg + 10'd1;
            end
            if (dmem_we_reg) begin
                word_idx_reg <= word_idx_reg + 32'd1;
            end
        end
    end

    // Status flags track the next state so that done and prog_loading
    // switch on the same edge the FSM lands in DONE.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            rx_ready_reg     <= 1'b0;
            prog_loading_reg <= 1'b1;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            rx_ready_reg     <= (state_next != ST_DONE);
            prog_loading_reg <= (state_next != ST_DONE);
            done_reg         <= (state_next == ST_DONE);
            err_reg          <= (state_next == ST_ERR);
        end
    end

    assign rx_ready     = rx_ready_reg;
    assign load_addr    = load_addr_reg;
    assign load_data    = load_data_reg;
    assign imem_we      = imem_we_reg;
    assign dmem_we      = dmem_we_reg;
    assign prog_loading = prog_loading_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: empty image, single line, data-only,
// stalled mixed image, header error and reset in the middle of a load.
module tb_prog_load_ctrl;

    logic         clk;
    logic         reset_x;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_ready;
    logic [31:0]  load_addr;
    logic [127:0] load_data;
    logic         imem_we;
    logic         dmem_we;
    logic         prog_loading;
    logic         done;
    logic         err;

    int total;
    int bad;

    int          st_n;
    int          n_overlap;
    logic [31:0]  st_addr [64];
    logic [127:0] st_data [64];
    logic         st_is_i [64];

    prog_load_ctrl #(
        .ADDR_LEN  (32),
        .IMEM_LINES(512),
        .DMEM_BASE (32'h0)
    ) dut (
        .clk         (clk),
        .reset_x     (reset_x),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .imem_we     (imem_we),
        .dmem_we     (dmem_we),
        .prog_loading(prog_loading),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we && dmem_we) begin
            n_overlap <= n_overlap + 1;
        end
        if ((imem_we || dmem_we) && st_n < 64) begin
            st_addr[st_n] <= load_addr;
            st_data[st_n] <= load_data;
            st_is_i[st_n] <= imem_we;
            st_n          <= st_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
        $display("check %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("rx_ready_timeout", 128'(rx_ready), 128'd1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_x = 1'b0;
        @(negedge clk);
        reset_x = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int t;
        total     = 0;
        bad       = 0;
        st_n      = 0;
        n_overlap = 0;
        reset_x   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;

        // Reset state
        #12;
        chk("rst_rx_ready", 128'(rx_ready), 128'd0);
        chk("rst_prog_loading", 128'(prog_loading), 128'd1);
        chk("rst_done_err", {126'd0, done, err}, 128'd0);
        chk("rst_load_addr", 128'(load_addr), 128'd0);
        chk("rst_load_data", load_data, 128'd0);
        @(negedge clk);
        reset_x = 1'b1;
        @(negedge clk);
        chk("rel_rx_ready", 128'(rx_ready), 128'd1);

        // Empty image
        base = st_n;
        send_word(32'd0, 0);
        send_word(32'd0, 0);
        chk("empty_done", 128'(done), 128'd1);
        chk("empty_prog_loading", 128'(prog_loading), 128'd0);
        chk("empty_rx_ready", 128'(rx_ready), 128'd0);
        chk("empty_strobes", 128'(st_n - base), 128'd0);

        // One imem line
        do_reset();
        send_word(32'd1, 0);
        send_word(32'd0, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("line_imem_we", {126'd0, imem_we, dmem_we}, 128'd2);
        chk("line_addr", 128'(load_addr), 128'h0);
        chk("line_data", load_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("line_prog_loading_during", 128'(prog_loading), 128'd1);
        @(negedge clk);
        chk("line_we_drop", 128'(imem_we), 128'd0);
        chk("line_done", {126'd0, done, prog_loading}, 128'd2);

        // Data only
        do_reset();
        send_word(32'd0, 0);
        send_word(32'd2, 0);
        send_word(32'hDEADBEEF, 0);
        chk("d0_we", {126'd0, imem_we, dmem_we}, 128'd1);
        chk("d0_addr", 128'(load_addr), 128'h0);
        chk("d0_data", 128'(load_data[127:96]), 128'hDEADBEEF);
        send_word(32'h12345678, 0);
        chk("d1_we", {126'd0, imem_we, dmem_we}, 128'd1);
        chk("d1_addr", 128'(load_addr), 128'h4);
        chk("d1_data", 128'(load_data[127:96]), 128'h12345678);
        @(negedge clk);
        chk("d_done", {126'd0, done, prog_loading}, 128'd2);

        // Mixed image with random stalls
        do_reset();
        base = st_n;
        send_word(32'd2, 3);
        send_word(32'd1, 3);
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(8'(8'h10 + i));
        end
        send_word(32'hCAFEF00D, 3);
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mix_done", 128'(done), 128'd1);
        chk("mix_count", 128'(st_n - base), 128'd3);
        chk("mix_kinds", {125'd0, st_is_i[base], st_is_i[base+1], st_is_i[base+2]}, 128'd6);
        chk("mix_addr0", 128'(st_addr[base]), 128'h00);
        chk("mix_addr1", 128'(st_addr[base+1]), 128'h10);
        chk("mix_addr2", 128'(st_addr[base+2]), 128'h00);
        chk("mix_line0", st_data[base], 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        chk("mix_line1", st_data[base+1], 128'h2F2E2D2C_2B2A2928_27262524_23222120);
        chk("mix_word", 128'(st_data[base+2][127:96]), 128'hCAFEF00D);
        chk("mix_overlap", 128'(n_overlap), 128'd0);

        // Header error: N_I = 513
        do_reset();
        base = st_n;
        send_word(32'd513, 0);
        send_word(32'd0, 0);
        chk("err_flag", 128'(err), 128'd1);
        chk("err_prog_loading", 128'(prog_loading), 128'd1);
        chk("err_rx_ready", 128'(rx_ready), 128'd1);
        for (int i = 0; i < 100; i++) send_byte(8'($urandom_range(0, 255)));
        chk("err_no_strobes", 128'(st_n - base), 128'd0);
        chk("err_sticky", {125'd0, err, done, rx_ready}, 128'd5);

        // Reset after 5 of 16 line bytes, then a fresh image
        do_reset();
        send_word(32'd1, 0);
        send_word(32'd0, 0);
        for (int i = 0; i < 5; i++) send_byte(8'hEE);
        reset_x = 1'b0;
        #1;
        chk("mid_rst_rx_ready", 128'(rx_ready), 128'd0);
        chk("mid_rst_flags", {124'd0, prog_loading, done, err, imem_we}, 128'd8);
        chk("mid_rst_data", load_data, 128'd0);
        chk("mid_rst_addr", 128'(load_addr), 128'd0);
        @(negedge clk);
        reset_x = 1'b1;
        @(negedge clk);
        send_word(32'd1, 0);
        send_word(32'd1, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
        chk("fresh_imem_we", {126'd0, imem_we, dmem_we}, 128'd2);
        chk("fresh_line", load_data, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);
        send_word(32'h11223344, 0);
        chk("fresh_dmem_we", {126'd0, imem_we, dmem_we}, 128'd1);
        chk("fresh_word", 128'(load_data[127:96]), 128'h11223344);
        chk("fresh_daddr", 128'(load_addr), 128'h0);
        @(negedge clk);
        chk("fresh_done", {126'd0, done, prog_loading}, 128'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
